// File: rtl/blit_pkg.sv
// rtl/blit_pkg.sv - shared state enum, default raster size and coordinate widths for the screen blitter
package blit_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    DRAIN1 = 3'd2,
    DRAIN2 = 3'd3,
    FIN    = 3'd4
  } blit_state_e;

  localparam int H_RES_DEFAULT = 320;
  localparam int V_RES_DEFAULT = 240;

  localparam int X_W = 9;
  localparam int Y_W = 8;

endpackage

// File: rtl/blit_addr_gen.sv
// rtl/blit_addr_gen.sv - linear read address plus column/row counters walking the frame in raster order
module blit_addr_gen
  import blit_pkg::*;
#(
  parameter int H_RES  = H_RES_DEFAULT,
  parameter int V_RES  = V_RES_DEFAULT,
  parameter int ADDR_W = 17
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic [X_W-1:0]    cx,
  output logic [Y_W-1:0]    cy,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [X_W-1:0]    LAST_CX   = X_W'(H_RES - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [X_W-1:0]    cx_q, cx_d;
  logic [Y_W-1:0]    cy_q, cy_d;

  // Address is a plain incrementer; column wraps at the line end and bumps the row.
  always_comb begin
    addr_d = addr_q;
    cx_d   = cx_q;
    cy_d   = cy_q;
    if (clear) begin
      addr_d = '0;
      cx_d   = '0;
      cy_d   = '0;
    end else if (advance) begin
      addr_d = addr_q + 1'b1;
      if (cx_q == LAST_CX) begin
        cx_d = '0;
        cy_d = cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
      cx_q   <= '0;
      cy_q   <= '0;
    end else begin
      addr_q <= addr_d;
      cx_q   <= cx_d;
      cy_q   <= cy_d;
    end
  end

  assign addr = addr_q;
  assign cx   = cx_q;
  assign cy   = cy_q;
  assign last = (addr_q == LAST_ADDR);

endmodule

// File: rtl/screen_blitter.sv
// rtl/screen_blitter.sv - copies a full-screen image from BRAM to the VGA adapter; BLIT_TRANSPARENT_EN skips key-coloured pixels
module screen_blitter
  import blit_pkg::*;
#(
  parameter int                   H_RES           = H_RES_DEFAULT,
  parameter int                   V_RES           = V_RES_DEFAULT,
  parameter int                   ADDR_W          = 17,
  parameter int                   COLOUR_W        = 8,
  parameter logic [COLOUR_W-1:0]  TRANSPARENT_KEY = '0
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic                abort,
  output logic [ADDR_W-1:0]   rdaddress,
  input  logic [COLOUR_W-1:0] q,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  blit_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr;
  logic [X_W-1:0]    cx;
  logic [Y_W-1:0]    cy;
  logic              last;
  logic              gen_clear;
  logic              gen_advance;

  // Delay stage: coordinates of the address presented last cycle, aligned with q.
  logic              vld_q, vld_d;
  logic [X_W-1:0]    cx_dly_q, cx_dly_d;
  logic [Y_W-1:0]    cy_dly_q, cy_dly_d;

  // Output registers towards the VGA adapter.
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                plot_q, plot_d;
  logic                pixel_visible;

  // Counters only run while scanning; any exit from SCAN returns them to zero.
  assign gen_advance = (state_q == SCAN);
  assign gen_clear   = (state_q != SCAN) || abort || last;

  blit_addr_gen #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (gen_clear),
    .advance (gen_advance),
    .addr    (addr),
    .cx      (cx),
    .cy      (cy),
    .last    (last)
  );

`ifdef BLIT_TRANSPARENT_EN
  assign pixel_visible = (q != TRANSPARENT_KEY);
`else
  logic unused_key;
  assign unused_key    = ^TRANSPARENT_KEY;
  assign pixel_visible = 1'b1;
`endif

  // Next-state logic: abort wins over start in IDLE and cancels any pass in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !abort) state_d = SCAN;
      SCAN:    if (abort) state_d = IDLE; else if (last) state_d = DRAIN1;
      DRAIN1:  state_d = abort ? IDLE : DRAIN2;
      DRAIN2:  state_d = abort ? IDLE : FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pipeline: tag addresses issued in SCAN, then register the returned pixel.
  always_comb begin
    vld_d    = (state_q == SCAN) && !abort;
    cx_dly_d = cx;
    cy_dly_d = cy;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = vld_q && !abort && pixel_visible;
    if (vld_q) begin
      x_d      = cx_dly_q;
      y_d      = cy_dly_q;
      colour_d = q;
    end
  end

  // State, delay stage and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      vld_q    <= 1'b0;
      cx_dly_q <= '0;
      cy_dly_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vld_q    <= vld_d;
      cx_dly_q <= cx_dly_d;
      cy_dly_q <= cy_dly_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
    end
  end

  assign rdaddress = addr;
  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign plot      = plot_q;
  assign busy      = (state_q == SCAN) || (state_q == DRAIN1) || (state_q == DRAIN2);
  assign done      = (state_q == FIN);

endmodule

// File: tb/tb_screen_blitter.sv
// tb/tb_screen_blitter.sv - table-driven and randomized checks of screen_blitter on a 4x3 and a 320x240 frame
module tb_screen_blitter;

  localparam int SH = 4;
  localparam int SV = 3;
  localparam int SN = SH * SV;
  localparam int FH = 320;
  localparam int FV = 240;
  localparam int FN = FH * FV;
  localparam logic [7:0] KEY = 8'h00;
`ifdef BLIT_TRANSPARENT_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;

  logic        start_s = 1'b0, abort_s = 1'b0;
  logic [16:0] rdaddress_s;
  logic [7:0]  q_s = 8'h00;
  logic [8:0]  x_s;
  logic [7:0]  y_s, colour_s;
  logic        plot_s, busy_s, done_s;

  logic        start_f = 1'b0, abort_f = 1'b0;
  logic [16:0] rdaddress_f;
  logic [7:0]  q_f = 8'h00;
  logic [8:0]  x_f;
  logic [7:0]  y_f, colour_f;
  logic        plot_f, busy_f, done_f;

  logic [7:0] mem_s [0:SN-1];
  logic [7:0] mem_f [0:FN-1];

  always #5 clk = ~clk;

  screen_blitter #(.H_RES(SH), .V_RES(SV)) dut_s (
    .clock(clk), .resetn(resetn), .start(start_s), .abort(abort_s),
    .rdaddress(rdaddress_s), .q(q_s), .x(x_s), .y(y_s), .colour(colour_s),
    .plot(plot_s), .busy(busy_s), .done(done_s)
  );

  screen_blitter dut_f (
    .clock(clk), .resetn(resetn), .start(start_f), .abort(abort_f),
    .rdaddress(rdaddress_f), .q(q_f), .x(x_f), .y(y_f), .colour(colour_f),
    .plot(plot_f), .busy(busy_f), .done(done_f)
  );

  // BRAM models with one-cycle read latency.
  always @(posedge clk) begin
    if (rdaddress_s < 17'(SN)) q_s <= mem_s[rdaddress_s[3:0]];
    if (rdaddress_f < 17'(FN)) q_f <= mem_f[rdaddress_f];
  end

  typedef struct packed {
    logic        start;
    logic        abort;
    logic        chk_addr;
    logic [16:0] addr;
    logic        chk_pix;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [7:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  // Expected outputs c cycles after the start edge of a 4x3 pass, aborted after cycle ab_rel (-1: none).
  function automatic vec_t model(input int c, input int ab_rel);
    vec_t v;
    int k;
    v = '0;
    if (c >= 1 && c <= SN + 3 && !(ab_rel >= 0 && c > ab_rel)) begin
      v.busy = (c <= SN + 2);
      v.done = (c == SN + 3);
      if (c <= SN) begin
        v.chk_addr = 1'b1;
        v.addr     = 17'(c - 1);
      end
      if (c >= 3 && c <= SN + 2) begin
        k         = c - 3;
        v.chk_pix = 1'b1;
        v.x       = 9'(k % SH);
        v.y       = 8'(k / SH);
        v.colour  = mem_s[k];
        v.plot    = !(TR && mem_s[k] == KEY);
      end
    end
    return v;
  endfunction

  // st0/st1: cycles where a start takes effect; ab: abort cycle of the first pass (-1 none).
  task automatic build(input int len, input int st0, input int st1, input int ab,
                       input logic [63:0] smask, input logic [63:0] amask);
    vecs.delete();
    for (int t = 0; t < len; t++) begin
      vec_t v;
      int s;
      s = (st1 >= 0 && t > st1) ? st1 : st0;
      v = model(t - s, (s == st0 && ab >= 0) ? ab - st0 : -1);
      v.start = smask[t];
      v.abort = amask[t];
      vecs.push_back(v);
    end
  endtask

  task automatic apply();
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      start_s = vecs[i].start;
      abort_s = vecs[i].abort;
      @(negedge clk);
      check("busy", i, 32'(busy_s), 32'(vecs[i].busy));
      check("plot", i, 32'(plot_s), 32'(vecs[i].plot));
      check("done", i, 32'(done_s), 32'(vecs[i].done));
      if (vecs[i].chk_addr) check("rdaddress", i, 32'(rdaddress_s), 32'(vecs[i].addr));
      if (vecs[i].chk_pix) begin
        check("x", i, 32'(x_s), 32'(vecs[i].x));
        check("y", i, 32'(y_s), 32'(vecs[i].y));
        check("colour", i, 32'(colour_s), 32'(vecs[i].colour));
      end
    end
    @(posedge clk);
    #1;
    start_s = 1'b0;
    abort_s = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdaddress_s"}, -1, 32'(rdaddress_s), 0);
    check({tag, "_x_s"}, -1, 32'(x_s), 0);
    check({tag, "_y_s"}, -1, 32'(y_s), 0);
    check({tag, "_colour_s"}, -1, 32'(colour_s), 0);
    check({tag, "_plot_s"}, -1, 32'(plot_s), 0);
    check({tag, "_busy_s"}, -1, 32'(busy_s), 0);
    check({tag, "_done_s"}, -1, 32'(done_s), 0);
    check({tag, "_rdaddress_f"}, -1, 32'(rdaddress_f), 0);
    check({tag, "_plot_f"}, -1, 32'(plot_f), 0);
    check({tag, "_busy_f"}, -1, 32'(busy_f), 0);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < SN; k++) mem_s[k] = 8'(k);
    if (TR) begin
      mem_s[0] = 8'h80;
      mem_s[2] = 8'h00;
      mem_s[7] = 8'h00;
    end
  endtask

  initial begin
    int ab, st1, p, len;
    logic [63:0] sm, am;
    int plots, exp_plots, dones, done_cyc, pix_bad;
    logic [8:0] lx;
    logic [7:0] ly, lc;

    load_ramp();
    for (int k = 0; k < FN; k++) mem_f[k] = 8'($urandom);
    mem_f[FN-1] = mem_f[FN-1] | 8'h01;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Basic pass; start pulses in SCAN and FIN must be ignored.
    sm = 64'h1 | (64'h1 << 5) | (64'h1 << 15);
    build(19, 0, -1, -1, sm, 64'h0);
    apply();

    // Abort in cycle 5, start+abort together in IDLE, then clean restart.
    sm = 64'h1 | (64'h1 << 7) | (64'h1 << 8);
    am = (64'h1 << 5) | (64'h1 << 7);
    build(25, 0, 8, 5, sm, am);
    apply();

    // Start held high: back-to-back passes separated by FIN plus one IDLE cycle.
    build(32, 0, 16, -1, 64'hFFFF_FFFF, 64'h0);
    apply();

    // Randomized image contents, abort points and stray start pulses.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < SN; k++) mem_s[k] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      ab  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 14)) : -1;
      st1 = ((ab >= 0) ? ab + 1 : 16) + int'($urandom_range(0, 2));
      p   = int'($urandom_range(1, (ab >= 0) ? ab : 14));
      len = st1 + 17;
      sm  = 64'h1 | (64'h1 << p) | (64'h1 << st1);
      am  = (ab >= 0) ? (64'h1 << ab) : 64'h0;
      build(len, 0, st1, ab, sm, am);
      apply();
    end

    // Asynchronous reset in cycle 7 of a pass, then a clean repeat.
    load_ramp();
    @(posedge clk);
    #1;
    start_s = 1'b1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    build(19, 0, -1, -1, 64'h1, 64'h0);
    apply();

    // Full 320x240 pass against random image data.
    exp_plots = 0;
    for (int k = 0; k < FN; k++) if (!(TR && mem_f[k] == KEY)) exp_plots++;
    plots = 0; dones = 0; done_cyc = -1; pix_bad = 0;
    lx = '0; ly = '0; lc = '0;
    @(posedge clk);
    #1;
    start_f = 1'b1;
    @(posedge clk);
    #1;
    start_f = 1'b0;
    for (int c = 1; c <= FN + 5; c++) begin
      @(negedge clk);
      if (plot_f) begin
        plots++;
        if (c < 3 || c > FN + 2) pix_bad++;
        else if (x_f != 9'((c - 3) % FH) || y_f != 8'((c - 3) / FH) || colour_f != mem_f[c - 3]) pix_bad++;
        lx = x_f; ly = y_f; lc = colour_f;
      end
      if (done_f) begin
        dones++;
        done_cyc = c;
      end
    end
    check("full_plot_count", FN, plots, exp_plots);
    check("full_pixels_wrong", FN, pix_bad, 0);
    check("full_last_x", FN, 32'(lx), 319);
    check("full_last_y", FN, 32'(ly), 239);
    check("full_last_colour", FN, 32'(lc), 32'(mem_f[FN-1]));
    check("full_done_count", FN, dones, 1);
    check("full_done_cycle", FN, done_cyc, FN + 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
